// File: rtl/sprite_compositor_if.sv
// Pixel-side bundle for sprite_compositor: per-layer pixel inputs, frame controls and RGB outputs.
// The master modport drives pixels in and receives RGB; the slave modport is the compositor.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS  = 2,
    parameter int COLOR_DEPTH = 2
);
    logic                              active;
    logic                              frame_start;
    logic [9:0]                        ycoord;
    logic [NUM_LAYERS*COLOR_DEPTH-1:0] layer_color;
    logic [NUM_LAYERS-1:0]             layer_active;
    logic [NUM_LAYERS*COLOR_DEPTH-1:0] layer_key;
    logic [NUM_LAYERS-1:0]             layer_enable_in;
    logic [NUM_LAYERS-1:0]             flash_trigger;
    logic [7:0]                        vga_r;
    logic [7:0]                        vga_g;
    logic [7:0]                        vga_b;
    logic                              pix_valid;
    logic                              collision;

    modport master (
        output active, frame_start, ycoord, layer_color, layer_active, layer_key,
               layer_enable_in, flash_trigger,
        input  vga_r, vga_g, vga_b, pix_valid, collision
    );

    modport slave (
        input  active, frame_start, ycoord, layer_color, layer_active, layer_key,
               layer_enable_in, flash_trigger,
        output vga_r, vga_g, vga_b, pix_valid, collision
    );
endinterface

// File: rtl/sprite_compositor.sv
// N-layer priority sprite compositor: transparency keys, floor/sky background, 2-stage RGB pipeline,
// per-frame collision report and frame-synchronous enables. Optional hit flash: COMPOSITOR_FLASH_EN.
module sprite_compositor #(
    parameter int NUM_LAYERS    = 2,
    parameter int COLOR_DEPTH   = 2,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FLOOR_HEIGHT  = 40,
    parameter int FLASH_FRAMES  = 8
) (
    input  logic               clk,
    input  logic               reset,
    sprite_compositor_if.slave px
);
    localparam logic [COLOR_DEPTH-1:0] BLACK_CODE = COLOR_DEPTH'(0);
    localparam logic [COLOR_DEPTH-1:0] WHITE_CODE = COLOR_DEPTH'(1);
    localparam logic [COLOR_DEPTH-1:0] RED_CODE   = COLOR_DEPTH'(2);
    localparam logic [COLOR_DEPTH-1:0] BLUE_CODE  = COLOR_DEPTH'(3);

    localparam logic [23:0] COLOR_BLACK = 24'h000000;
    localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
    localparam logic [23:0] COLOR_RED   = 24'hFF0000;
    localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;

    localparam logic [9:0] FLOOR_Y = 10'(SCREEN_HEIGHT - FLOOR_HEIGHT);
    localparam int         FW      = $clog2(FLASH_FRAMES + 1);

    function automatic logic [23:0] map_code(input logic [COLOR_DEPTH-1:0] code);
        case (code)
            BLACK_CODE: map_code = COLOR_BLACK;
            WHITE_CODE: map_code = COLOR_WHITE;
            RED_CODE:   map_code = COLOR_RED;
            BLUE_CODE:  map_code = COLOR_BLUE;
            default:    map_code = 24'h000000;
        endcase
    endfunction

    logic [NUM_LAYERS-1:0]  r_en_q;
    logic [NUM_LAYERS-1:0]  w_opaque;
    logic [COLOR_DEPTH-1:0] w_color [NUM_LAYERS];
    logic [COLOR_DEPTH-1:0] w_code;
    logic                   w_overlap;

    logic [COLOR_DEPTH-1:0] r_code_p1;
    logic                   r_vld_p1;
    logic                   r_ovl_p1;
    logic [23:0]            r_rgb_p2;
    logic                   r_vld_p2;
    logic                   r_coll_live;
    logic                   r_collision;

`ifdef COMPOSITOR_FLASH_EN
    logic [FW-1:0] r_flash_cnt [NUM_LAYERS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (reset) begin
                r_flash_cnt[i] <= '0;
            end else if (px.flash_trigger[i]) begin
                r_flash_cnt[i] <= FW'(FLASH_FRAMES);
            end else if (px.frame_start && (r_flash_cnt[i] != '0)) begin
                r_flash_cnt[i] <= r_flash_cnt[i] - FW'(1);
            end
        end
    end

    // An odd count is necessarily non-zero, so the LSB alone selects the white phase.
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_color[i] = r_flash_cnt[i][0] ? WHITE_CODE
                                           : px.layer_color[i*COLOR_DEPTH +: COLOR_DEPTH];
        end
    end
`else
    logic w_unused_flash;
    assign w_unused_flash = (^px.flash_trigger) ^ (FW == 0);

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_color[i] = px.layer_color[i*COLOR_DEPTH +: COLOR_DEPTH];
        end
    end
`endif

    always_comb begin
        w_opaque = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_opaque[i] = px.layer_active[i] && r_en_q[i] &&
                          (px.layer_color[i*COLOR_DEPTH +: COLOR_DEPTH] !=
                           px.layer_key[i*COLOR_DEPTH +: COLOR_DEPTH]);
        end
    end

    // Scan from the lowest priority up so layer 0 is the last (winning) assignment.
    always_comb begin
        w_code = (px.ycoord >= FLOOR_Y) ? BLACK_CODE : WHITE_CODE;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_code = w_color[i];
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more layers are opaque.
    assign w_overlap = px.active && ((w_opaque & (w_opaque - NUM_LAYERS'(1))) != '0);

    // Stage 1: selected code, delayed active, overlap flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_ovl_p1  <= 1'b0;
        end else begin
            r_code_p1 <= w_code;
            r_vld_p1  <= px.active;
            r_ovl_p1  <= w_overlap;
        end
    end

    // Stage 2: colour lookup with blanking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb_p2 <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_rgb_p2 <= r_vld_p1 ? map_code(r_code_p1) : 24'h000000;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // An overlap arriving with frame_start is counted toward the frame that is just beginning.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_q      <= '1;
            r_coll_live <= 1'b0;
            r_collision <= 1'b0;
        end else if (px.frame_start) begin
            r_en_q      <= px.layer_enable_in;
            r_collision <= r_coll_live;
            r_coll_live <= r_ovl_p1;
        end else if (r_ovl_p1) begin
            r_coll_live <= 1'b1;
        end
    end

    assign px.vga_r     = r_rgb_p2[23:16];
    assign px.vga_g     = r_rgb_p2[15:8];
    assign px.vga_b     = r_rgb_p2[7:0];
    assign px.pix_valid = r_vld_p2;
    assign px.collision = r_collision;
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: table-driven pixels through a latency scoreboard, plus enable,
// collision, reset and flash sequences.
module tb_sprite_compositor;
    localparam logic [1:0] BK = 2'd0, WH = 2'd1, RD = 2'd2, BL = 2'd3;
    localparam logic [23:0] C_BLACK = 24'h000000, C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_RED = 24'hFF0000, C_BLUE = 24'h0000FF;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_compositor_if #(.NUM_LAYERS(2), .COLOR_DEPTH(2)) px ();

    sprite_compositor #(
        .NUM_LAYERS(2), .COLOR_DEPTH(2), .SCREEN_HEIGHT(480),
        .FLOOR_HEIGHT(40), .FLASH_FRAMES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .px(px)
    );

    typedef struct {
        int          due;
        int          id;
        logic [23:0] rgb;
        logic        vld;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        act;
        logic [9:0]  y;
        logic [3:0]  col;
        logic [1:0]  lact;
        logic [3:0]  key;
        logic [23:0] rgb;
        logic        vld;
    } vec_t;
    vec_t vt[12];

    int next_id = 0;

    task automatic check(input string nm, input int id, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s#%0d: got %h, required %h", nm, id, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("rgb", e.id, {8'h0, px.vga_r, px.vga_g, px.vga_b}, {8'h0, e.rgb});
            check("pix_valid", e.id, {31'h0, px.pix_valid}, {31'h0, e.vld});
        end
    end

    // Present one pixel for the current cycle, log its expected output, advance one cycle.
    task automatic drive(input logic fs, input logic act, input logic [9:0] y,
                         input logic [3:0] col, input logic [1:0] lact, input logic [3:0] key,
                         input logic [23:0] rgb, input logic vld);
        exp_t e;
        px.frame_start  = fs;
        px.active       = act;
        px.ycoord       = y;
        px.layer_color  = col;
        px.layer_active = lact;
        px.layer_key    = key;
        e.due = cyc + 2;
        e.id  = next_id;
        e.rgb = rgb;
        e.vld = vld;
        next_id++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        px.frame_start = 1'b0;
    endtask

    task automatic idle(input int n, input logic fs);
        for (int k = 0; k < n; k++) drive(fs, 1'b0, 10'd0, 4'h0, 2'b00, 4'h0, C_BLACK, 1'b0);
    endtask

    task automatic ovl_px();
        drive(1'b0, 1'b1, 10'd100, {BL, RD}, 2'b11, 4'h0, C_RED, 1'b1);
    endtask

    task automatic l0_px(input logic [23:0] rgb);
        drive(1'b0, 1'b1, 10'd100, {BL, RD}, 2'b01, 4'h0, rgb, 1'b1);
    endtask

    task automatic fs_l0(input logic [23:0] rgb);
        idle(1, 1'b1);
        l0_px(rgb);
    endtask

    function automatic logic [23:0] fl(input logic white);
`ifdef COMPOSITOR_FLASH_EN
        fl = white ? C_WHITE : C_RED;
`else
        fl = white ? C_RED : C_RED;
`endif
    endfunction

    initial begin
        vt[0]  = '{1'b1, 10'd100, {BL, RD}, 2'b11, {BK, BK}, C_RED,   1'b1};
        vt[1]  = '{1'b1, 10'd100, {RD, BL}, 2'b11, {BK, BL}, C_RED,   1'b1};
        vt[2]  = '{1'b1, 10'd460, {BK, BK}, 2'b00, {BK, BK}, C_BLACK, 1'b1};
        vt[3]  = '{1'b1, 10'd100, {BK, BK}, 2'b00, {BK, BK}, C_WHITE, 1'b1};
        vt[4]  = '{1'b0, 10'd100, {BL, RD}, 2'b11, {BK, BK}, C_BLACK, 1'b0};
        vt[5]  = '{1'b1, 10'd100, {BL, RD}, 2'b10, {BK, BK}, C_BLUE,  1'b1};
        vt[6]  = '{1'b1, 10'd439, {BL, RD}, 2'b11, {BL, RD}, C_WHITE, 1'b1};
        vt[7]  = '{1'b1, 10'd440, {BL, RD}, 2'b11, {BL, RD}, C_BLACK, 1'b1};
        vt[8]  = '{1'b1, 10'd200, {WH, RD}, 2'b01, {BK, WH}, C_RED,   1'b1};
        vt[9]  = '{1'b1, 10'd200, {WH, BK}, 2'b11, {BL, BL}, C_BLACK, 1'b1};
        vt[10] = '{1'b0, 10'd460, {BK, BK}, 2'b00, {BK, BK}, C_BLACK, 1'b0};
        vt[11] = '{1'b1, 10'd0,   {RD, BL}, 2'b10, {RD, BK}, C_WHITE, 1'b1};

        reset              = 1'b1;
        px.frame_start     = 1'b0;
        px.active          = 1'b1;
        px.ycoord          = 10'd100;
        px.layer_color     = {BL, RD};
        px.layer_active    = 2'b11;
        px.layer_key       = 4'h0;
        px.layer_enable_in = 2'b11;
        px.flash_trigger   = 2'b00;

        // Reset state, and the cleared pipeline emerging first after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rgb", 0, {8'h0, px.vga_r, px.vga_g, px.vga_b}, 32'h0);
        check("reset_valid", 0, {31'h0, px.pix_valid}, 32'h0);
        check("reset_collision", 0, {31'h0, px.collision}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back('{cyc + 1, 999, C_BLACK, 1'b0});

        // Table vectors back to back
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, vt[i].act, vt[i].y, vt[i].col, vt[i].lact, vt[i].key,
                  vt[i].rgb, vt[i].vld);
        end

        // Enable change is deferred to the frame boundary
        px.layer_enable_in = 2'b10;
        ovl_px();
        drive(1'b1, 1'b1, 10'd100, {BL, RD}, 2'b11, 4'h0, C_RED, 1'b1);
        drive(1'b0, 1'b1, 10'd100, {BL, RD}, 2'b11, 4'h0, C_BLUE, 1'b1);
        px.layer_enable_in = 2'b11;
        drive(1'b1, 1'b1, 10'd100, {BL, RD}, 2'b11, 4'h0, C_BLUE, 1'b1);
        ovl_px();
        idle(3, 1'b0);

        // Collision reported one frame late, then cleared
        reset = 1'b1;
        idle(2, 1'b0);
        reset = 1'b0;
        idle(1, 1'b1);
        check("coll_first_frame", 1, {31'h0, px.collision}, 32'h0);
        ovl_px();
        idle(3, 1'b0);
        idle(1, 1'b1);
        check("coll_next_frame", 2, {31'h0, px.collision}, 32'h1);
        idle(3, 1'b0);
        check("coll_held", 3, {31'h0, px.collision}, 32'h1);
        idle(1, 1'b1);
        check("coll_cleared", 4, {31'h0, px.collision}, 32'h0);

        // Overlap reaching the sticky bit on the frame_start edge belongs to the new frame
        idle(2, 1'b0);
        ovl_px();
        idle(1, 1'b1);
        check("coll_coincident_old", 5, {31'h0, px.collision}, 32'h0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        check("coll_coincident_new", 6, {31'h0, px.collision}, 32'h1);

        // Mid-frame reset clears both the report and the sticky bit
        ovl_px();
        idle(3, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;
        check("coll_reset", 7, {31'h0, px.collision}, 32'h0);
        idle(1, 1'b1);
        check("coll_after_reset", 8, {31'h0, px.collision}, 32'h0);

        // Hit flash on layer 0, including a reload on a frame_start cycle
        px.flash_trigger = 2'b01;
        idle(1, 1'b0);
        px.flash_trigger = 2'b00;
        l0_px(fl(1'b0));
        fs_l0(fl(1'b1));
        px.flash_trigger = 2'b01;
        idle(1, 1'b1);
        px.flash_trigger = 2'b00;
        l0_px(fl(1'b0));
        fs_l0(fl(1'b1));
        fs_l0(fl(1'b0));
        fs_l0(fl(1'b1));
        fs_l0(fl(1'b0));
        fs_l0(fl(1'b0));

        // Drain the scoreboard within a bounded number of cycles
        idle(2, 1'b0);
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #1;
        check("scoreboard_drained", 0, sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-layer successor to the two-player sprite mixer. Each cycle it takes one pixel per sprite renderer channel, resolves per-layer transparency keys and a fixed priority order, and substitutes the floor/sky background where no layer is opaque. It maps the winning colour code to 24-bit RGB through a 2-stage registered pipeline. It also reports per-frame sprite overlap (collision) and supports frame-synchronous layer enables.

## Interface
- `NUM_LAYERS`, 2, number of sprite channels; layer 0 has the highest priority (range 1–8).
- `COLOR_DEPTH`, 2, bits per colour code; codes use the `COLOR_*_CODE` values in params.vh.
- `SCREEN_HEIGHT`, 480, visible lines.
- `FLOOR_HEIGHT`, 40, floor band height in lines.
- `FLASH_FRAMES`, 8, hit-flash duration in frames (used only with the flash feature).
- `clk` in 1: pixel clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `active` in 1: the current pixel is in the visible region.
- `frame_start` in 1: one-cycle pulse at the first cycle of each frame.
- `ycoord` in 10: current pixel line.
- `layer_color` in NUM_LAYERS*COLOR_DEPTH: layer i occupies bits [i*COLOR_DEPTH +: COLOR_DEPTH].
- `layer_active` in NUM_LAYERS: layer i covers the pixel.
- `layer_key` in NUM_LAYERS*COLOR_DEPTH: transparency code for each layer.
- `layer_enable_in` in NUM_LAYERS: requested enables, applied at the next frame.
- `flash_trigger` in NUM_LAYERS: start a hit flash on layer i (flash feature only).
- `vga_r`, `vga_g`, `vga_b` out 8 each: registered RGB.
- `pix_valid` out 1: registered, delayed `active`.
- `collision` out 1: two or more layers overlapped during the previous frame.

## Operation
- **Opaque rule.** Layer i is opaque when all of the following hold:
  - `layer_active[i]`,
  - `layer_enable_q[i]`,
  - its colour is not equal to `layer_key[i]`.
- **Winner.** The lowest-index opaque layer wins.
- **Background.** If no layer is opaque, the pixel takes the background colour:
  - BLACK when `ycoord >= SCREEN_HEIGHT - FLOOR_HEIGHT`,
  - WHITE otherwise.
- **Stage 1 (registered).** Captures:
  - the selected code,
  - `active`,
  - `overlap`: opaque count >= 2, gated by `active`.
- **Stage 2 (registered).** Maps the code to RGB and drives `pix_valid`.
  - The output is forced to 0 when the delayed active bit is 0.
  - An unmapped code outputs 0.
- **Layer enables.**
  - `layer_enable_q` loads `layer_enable_in` only on `frame_start`, so an enable never changes mid-frame.
  - `layer_enable_q` resets to all ones.
- **Collision.**
  - `coll_live` is a sticky bit, set by stage-1 `overlap`.
  - On `frame_start`: `collision <= coll_live`, then `coll_live` clears.
  - If `frame_start` and `overlap` occur in the same cycle, `collision` takes the old `coll_live` value, and `coll_live` is set to 1 (the overlap belongs to the new frame).
  - `collision` holds its value for the whole frame.
- **Reset** (any cycle, including mid-frame):
  - RGB = 0, `pix_valid` = 0, `collision` = 0,
  - `coll_live` = 0, pipeline cleared, enables all ones, flash counters 0.

## Timing
- Latency from input pixel to RGB and `pix_valid` is 2 cycles. Throughput is 1 pixel per cycle, with no stalls.
- The overlap flag reaches `coll_live` 2 cycles after the input pixel: stage-1 capture, then the sticky update.
- The first cycle after `reset` deasserts produces output from pipeline contents that were cleared, so RGB = 0 and `pix_valid` = 0 for 2 cycles.
- A `layer_enable_in` change takes effect for pixels presented on the cycle after the `frame_start` pulse.
- `collision` updates on the clock edge that samples `frame_start`.

## Configuration
- Macro: `COMPOSITOR_FLASH_EN`.
- **Defined:**
  - Each layer has a flash counter.
  - `flash_trigger[i]` loads counter i with `FLASH_FRAMES`.
  - Each counter decrements on `frame_start` while it is non-zero.
  - While counter i is non-zero and its LSB is 1, an opaque layer-i pixel outputs WHITE_CODE instead of its own colour.
  - A retrigger while counting reloads the counter.
  - If a trigger arrives in the same cycle as `frame_start`, the load wins.
- **Undefined:**
  - No counters exist.
  - `flash_trigger` is ignored.
  - Colours pass through unchanged.

## Test plan
- **Priority:** NUM_LAYERS=2; L0=RED, L1=BLUE, both active, keys=BLACK -> after 2 cycles, RGB = COLOR_RED and `pix_valid` = 1.
- **Transparency:** L0 colour == `layer_key[0]` = BLUE, L1 = RED active -> COLOR_RED. With no layer active and ycoord=460 -> COLOR_BLACK; with ycoord=100 -> COLOR_WHITE.
- **Blanking:** `active` = 0 with any inputs -> RGB = 0 and `pix_valid` = 0 exactly 2 cycles later.
- **Enable sync:**
  - Drop `layer_enable_in[0]` mid-frame -> L0 is still drawn.
  - After `frame_start`, an L0+L1 pixel outputs the L1 colour.
- **Collision:**
  - One overlapping pixel in frame N -> `collision` = 1 after frame N+1's `frame_start`, and 0 after frame N+2's if there is no overlap.
  - An overlap coincident with `frame_start` is attributed to the new frame.
  - Reset mid-frame clears `collision`.
- **Flash (`COMPOSITOR_FLASH_EN`, FLASH_FRAMES=4):**
  - Trigger L0 -> L0 pixels alternate WHITE/own colour per frame for 4 frames, then show their normal colour.
  - Without the macro, no change.
